codec_spi_word_xfer: RTL and testbench

Single-word SPI transaction engine for the audio codec control port. It accepts one 16-bit register command word per handshake and serialises it on CS_n/SCLK/DIN, capturing DOUT. For verified writes it runs an automatic read-back transaction and reports whether the codec returned the written byte. It sits directly downstream of the codec register-table sequencer and drives the codec SPI pins.

---
 rtl/codec_spi_word_xfer.sv | 184 ++++++++++++++++++
 tb/tb_codec_spi_word_xfer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_spi_word_xfer.sv
// Single-word SPI transaction engine for the audio codec control port.
// Serialises one 16-bit command word on CS_n/SCLK/DIN and captures DOUT.
// A verified write runs a second read-back transaction and compares
// the returned byte with the written data byte.
module codec_spi_word_xfer #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic        iCLK_50,
    input  logic        iRESET_n,
    input  logic        iSTART,
    input  logic [15:0] iWORD,
    input  logic        iVERIFY,
    output logic        oREADY,
    output logic        oDONE,
    output logic [7:0]  oRDATA,
    output logic        oMATCH,
    output logic        oCS_n,
    output logic        oSCLK,
    output logic        oDIN,
    input  logic        iDOUT
);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLow,
        StHigh,
        StTrail,
        StDone
    } state_e;

    localparam logic [15:0] DivLast = 16'(CLK_DIV - 32'd1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        phase_q, phase_d;
    logic        verify_q, verify_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [6:0]  addr_q, addr_d;

    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        match_q, match_d;

    logic        div_end;

    assign div_end = (div_q == DivLast);

    // Next-state, datapath and output decode; outputs are derived from the
    // next state so that every pin is driven straight from a flop.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q + 16'd1;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        verify_d  = verify_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        match_d   = match_q;

        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    tx_d      = iWORD;
                    verify_d  = iVERIFY & ~iWORD[8];
                    wdata_d   = iWORD[7:0];
                    addr_d    = iWORD[15:9];
                    phase_d   = 1'b0;
                    bit_cnt_d = 5'd0;
                    state_d   = StLead;
                end
            end
            StLead: begin
                if (div_end) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                // DOUT is taken on the same edge that raises SCLK
                if (div_end) begin
                    rx_d    = {rx_q[14:0], iDOUT};
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (div_end) begin
                    tx_d      = {tx_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = (bit_cnt_q == 5'd15) ? StTrail : StLow;
                end
            end
            StTrail: begin
                if (div_end) begin
                    if (!phase_q && verify_q) begin
                        // Read-back of the address just written
                        tx_d      = {addr_q, 1'b1, 8'hFF};
                        phase_d   = 1'b1;
                        bit_cnt_d = 5'd0;
                        state_d   = StLead;
                    end else begin
                        rdata_d = rx_q[7:0];
                        match_d = phase_q && (rx_q[7:0] == wdata_q);
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Divider restarts on every state entry
        if (state_d != state_q) begin
            div_d = 16'd0;
        end

        cs_n_d  = !((state_d == StLow) || (state_d == StHigh));
        sclk_d  = !((state_d == StLead) || (state_d == StLow));
        din_d   = ((state_d == StLow) || (state_d == StHigh)) ? tx_d[15] : 1'b0;
        ready_d = (state_d == StIdle);
        done_d  = (state_d == StDone);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge iCLK_50) begin
        if (!iRESET_n) begin
            state_q   <= StIdle;
            div_q     <= 16'd0;
            tx_q      <= 16'd0;
            rx_q      <= 16'd0;
            bit_cnt_q <= 5'd0;
            phase_q   <= 1'b0;
            verify_q  <= 1'b0;
            wdata_q   <= 8'd0;
            addr_q    <= 7'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rdata_q   <= 8'd0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            verify_q  <= verify_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            match_q   <= match_d;
        end
    end

    assign oCS_n  = cs_n_q;
    assign oSCLK  = sclk_q;
    assign oDIN   = din_q;
    assign oREADY = ready_q;
    assign oDONE  = done_q;
    assign oRDATA = rdata_q;
    assign oMATCH = match_q;

endmodule

// File: tb/tb_codec_spi_word_xfer.sv
// Self-checking bench for codec_spi_word_xfer with a small codec model
// and a scoreboard of expected request completions and shifted words.
module tb_codec_spi_word_xfer;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        iRESET_n;
    logic        iSTART;
    logic [15:0] iWORD;
    logic        iVERIFY;
    logic        oREADY;
    logic        oDONE;
    logic [7:0]  oRDATA;
    logic        oMATCH;
    logic        oCS_n;
    logic        oSCLK;
    logic        oDIN;
    logic        iDOUT;

    always #5 clk = ~clk;

    codec_spi_word_xfer #(
        .CLK_DIV(D)
    ) dut (
        .iCLK_50 (clk),
        .iRESET_n(iRESET_n),
        .iSTART  (iSTART),
        .iWORD   (iWORD),
        .iVERIFY (iVERIFY),
        .oREADY  (oREADY),
        .oDONE   (oDONE),
        .oRDATA  (oRDATA),
        .oMATCH  (oMATCH),
        .oCS_n   (oCS_n),
        .oSCLK   (oSCLK),
        .oDIN    (oDIN),
        .iDOUT   (iDOUT)
    );

    typedef struct packed {
        logic [31:0] done_cyc;
        logic [7:0]  rdata;
        logic        match;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] word_q[$];

    int          passed = 0;
    int          checks = 0;
    int          ndone  = 0;
    logic [31:0] cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Codec model: shifts DIN in at SCLK rise, drives the reply byte on
    // DOUT after SCLK falls during the last eight bit periods.
    logic [7:0]  reply = 8'h00;
    logic        abort = 1'b0;
    int          bits = 0;
    int          cs_low = 0;
    logic [15:0] cap = 16'h0;
    logic        sclk_prev = 1'b1;
    logic        cs_prev = 1'b1;
    logic [31:0] rise_cyc = 0;
    logic        have_rise = 1'b0;

    always @(negedge clk) begin
        if (!oCS_n) cs_low++;
        if (oSCLK && !sclk_prev && !oCS_n) begin
            cap = {cap[14:0], oDIN};
            bits++;
        end
        if (!oSCLK && sclk_prev && !oCS_n) begin
            if (bits >= 8 && bits < 16) iDOUT = reply[15 - bits];
            else iDOUT = 1'b0;
        end
        if (!oCS_n && cs_prev && have_rise) begin
            chk("cs_gap_min", 32'(cyc - rise_cyc >= 2 * D), 32'd1);
        end
        if (oCS_n && !cs_prev) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
            if (!abort) begin
                if (word_q.size() == 0) begin
                    chk("extra_xfer", 32'(word_q.size()), 32'd1);
                end else begin
                    chk("din_word", 32'(cap), 32'(word_q.pop_front()));
                    chk("sclk_pulses", 32'(bits), 32'd16);
                    chk("cs_low_cycles", 32'(cs_low), 32'(32 * D));
                end
            end
            bits   = 0;
            cap    = 16'h0;
            cs_low = 0;
            iDOUT  = 1'b0;
        end
        sclk_prev = oSCLK;
        cs_prev   = oCS_n;
    end

    // Completion monitor: pops the scoreboard on each oDONE
    always @(negedge clk) begin
        if (oDONE) begin
            ndone++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(oDONE), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("rdata", 32'(oRDATA), 32'(e.rdata));
                chk("match", 32'(oMATCH), 32'(e.match));
                chk("ready_in_done", 32'(oREADY), 32'd0);
            end
        end
    end

    // Push expectations for a request accepted at the edge after this negedge
    task automatic push_exp(input logic [15:0] w, input logic v, input logic [7:0] rep);
        exp_t e;
        logic ver;
        ver        = v & ~w[8];
        e.done_cyc = cyc + 32'((ver ? 68 : 34) * D + 1);
        e.rdata    = rep;
        e.match    = ver && (rep == w[7:0]);
        exp_q.push_back(e);
        word_q.push_back(w);
        if (ver) word_q.push_back({w[15:9], 1'b1, 8'hFF});
    endtask

    task automatic request(input logic [15:0] w, input logic v, input logic [7:0] rep);
        @(negedge clk);
        reply   = rep;
        iWORD   = w;
        iVERIFY = v;
        iSTART  = 1'b1;
        chk("ready_at_request", 32'(oREADY), 32'd1);
        push_exp(w, v, rep);
        @(negedge clk);
        iSTART = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!oDONE && n < 80 * D + 20) begin
            @(negedge clk);
            n++;
        end
        if (!oDONE) chk("done_timeout", 32'(oDONE), 32'd1);
        @(negedge clk);
        chk("ready_after_done", 32'(oREADY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] prev_acc;
        iRESET_n = 1'b0;
        iSTART   = 1'b0;
        iWORD    = 16'h0;
        iVERIFY  = 1'b0;
        iDOUT    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(oCS_n), 32'd1);
        chk("rst_sclk", 32'(oSCLK), 32'd1);
        chk("rst_din", 32'(oDIN), 32'd0);
        chk("rst_ready", 32'(oREADY), 32'd1);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_rdata", 32'(oRDATA), 32'd0);
        chk("rst_match", 32'(oMATCH), 32'd0);
        iRESET_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain write
        request(16'h1A55, 1'b0, 8'hC3);
        wait_done();

        // Verified write, codec returns the written byte
        request(16'h1A55, 1'b1, 8'h55);
        wait_done();

        // Verified write, codec returns a different byte
        request(16'h1A55, 1'b1, 8'h54);
        wait_done();

        // Read request: verify flag ignored
        request(16'h4500, 1'b1, 8'hA7);
        wait_done();

        // Start pulse while busy must be ignored
        request(16'h3C81, 1'b0, 8'h0F);
        repeat (60) @(negedge clk);
        iWORD   = 16'hFFFF;
        iVERIFY = 1'b1;
        iSTART  = 1'b1;
        @(negedge clk);
        iSTART = 1'b0;
        wait_done();

        // Back-to-back with iSTART held high
        iWORD    = 16'h2201;
        iVERIFY  = 1'b0;
        reply    = 8'h3E;
        iSTART   = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!oREADY && n < 40 * D) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready", 32'(oREADY), 32'd1);
            if (i > 0) chk("b2b_period", cyc - prev_acc, 32'(34 * D + 2));
            prev_acc = cyc;
            push_exp(16'h2201, 1'b0, 8'h3E);
            @(negedge clk);
        end
        iSTART = 1'b0;
        wait_done();

        // Reset during bit 5 of a write
        request(16'h1A55, 1'b0, 8'h00);
        n = 0;
        while (bits != 5 && n < 20 * D) begin
            @(negedge clk);
            n++;
        end
        chk("reached_bit5", 32'(bits), 32'd5);
        void'(exp_q.pop_back());
        void'(word_q.pop_back());
        abort    = 1'b1;
        iRESET_n = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 32'(oCS_n), 32'd1);
        chk("abort_sclk", 32'(oSCLK), 32'd1);
        chk("abort_ready", 32'(oREADY), 32'd1);
        chk("abort_done", 32'(oDONE), 32'd0);
        iRESET_n = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (40 * D) @(negedge clk);
        request(16'h0A96, 1'b1, 8'h96);
        wait_done();

        repeat (20) @(negedge clk);
        chk("pending_exp", 32'(exp_q.size()), 32'd0);
        chk("pending_words", 32'(word_q.size()), 32'd0);
        chk("done_count", 32'(ndone), 32'd9);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
